// File: rtl/core_pkg.sv
// core_pkg: shared fetch-front-end types and width constants
package core_pkg;
  localparam int XLEN = 32;
  localparam int IMM_W = 16;
  localparam int JIDX_W = 26;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: sequential, branch and jump target computation with jump-over-branch priority
module next_pc_calc
  import core_pkg::*;
(
  input  logic [XLEN-1:0]   pc,
  input  logic              br_taken,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [XLEN-1:0]   br_pc,
  input  logic              jmp_taken,
  input  logic [JIDX_W-1:0] jmp_index,
  input  logic [XLEN-1:0]   jmp_pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              redirect,
  output logic [XLEN-1:0]   target
);
  logic [XLEN-1:0] br_target;
  logic [3:0] jmp_region;
  assign pc_plus4 = pc + XLEN'(4);
  assign br_target = br_pc + XLEN'(4) + {{(XLEN-IMM_W-2){br_imm[IMM_W-1]}}, br_imm, 2'b00};
  assign jmp_region = 4'((jmp_pc + XLEN'(4)) >> (XLEN-4));
  assign redirect = br_taken | jmp_taken;
  assign target = jmp_taken ? {jmp_region, jmp_index, 2'b00} : br_target;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing instruction reads and handing words to decode, with redirect flush
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_inst,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_pc_plus4,
  input  logic              if_ready,
  input  logic              br_taken,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [XLEN-1:0]   br_pc,
  input  logic              jmp_taken,
  input  logic [JIDX_W-1:0] jmp_index,
  input  logic [XLEN-1:0]   jmp_pc
);
  fetch_state_t state;
  logic [XLEN-1:0] pc, pc_plus4, target;
  logic redirect;
  next_pc_calc u_next_pc (
    .pc(pc),
    .br_taken(br_taken),
    .br_imm(br_imm),
    .br_pc(br_pc),
    .jmp_taken(jmp_taken),
    .jmp_index(jmp_index),
    .jmp_pc(jmp_pc),
    .pc_plus4(pc_plus4),
    .redirect(redirect),
    .target(target)
  );
  assign imem_req = state == REQ;
  assign imem_addr = pc;
  assign if_valid = state == HOLD;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      if_inst <= '0;
      if_pc <= '0;
      if_pc_plus4 <= '0;
    end else begin
      if (redirect) pc <= target;
      case (state)
        IDLE: state <= REQ;
        REQ: if (imem_ready) state <= redirect ? DROP : WAIT;
        WAIT: begin
          if (imem_rvalid) state <= redirect ? REQ : HOLD;
          else if (redirect) state <= DROP;
          if (imem_rvalid && !redirect) begin
            if_inst <= imem_rdata;
            if_pc <= pc;
            if_pc_plus4 <= pc_plus4;
          end
        end
        HOLD: begin
          if (redirect || if_ready) state <= REQ;
          if (!redirect && if_ready) pc <= pc_plus4;
        end
        DROP: if (imem_rvalid) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit against a transaction-level reference
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0040_0000;
  typedef struct {
    logic br;
    logic jmp;
    logic [15:0] imm;
    logic [31:0] bpc;
    logic [25:0] idx;
    logic [31:0] jpc;
    logic [31:0] exp_addr;
  } redir_vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req, imem_ready, imem_rvalid, if_valid, if_ready, br_taken, jmp_taken;
  logic [31:0] imem_addr, imem_rdata, if_inst, if_pc, if_pc_plus4, br_pc, jmp_pc;
  logic [15:0] br_imm;
  logic [25:0] jmp_index;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int due = 0;
  int lat_min = 1;
  int lat_max = 1;
  int ready_pct = 100;
  bit pend = 1'b0;
  logic [31:0] paddr = '0;
  bit m_started, m_out, m_stale, m_have;
  logic [31:0] m_pc, m_req_addr, m_inst, m_ipc, m_ipc4;
  redir_vec_t tbl [6];
  logic [31:0] seen [3];
  logic [31:0] held_inst, held_pc;
  int got;
  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .if_inst(if_inst),
    .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4),
    .if_ready(if_ready),
    .br_taken(br_taken),
    .br_imm(br_imm),
    .br_pc(br_pc),
    .jmp_taken(jmp_taken),
    .jmp_index(jmp_index),
    .jmp_pc(jmp_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] inst_of(logic [31:0] a);
    return a ^ 32'hC0DE_F00D;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model_step();
    logic [31:0] tgt, sx;
    bit redir, req, acc, resp, had;
    if (rst) begin
      m_started = 0;
      m_out = 0;
      m_stale = 0;
      m_have = 0;
      m_pc = RPC;
      m_inst = '0;
      m_ipc = '0;
      m_ipc4 = '0;
      return;
    end
    sx = {{16{br_imm[15]}}, br_imm};
    redir = br_taken | jmp_taken;
    tgt = jmp_taken ? (((jmp_pc + 32'd4) & 32'hF000_0000) | ({6'b0, jmp_index} << 2)) : br_pc + 32'd4 + (sx << 2);
    req = m_started && !m_out && !m_have;
    had = m_have;
    if (!m_started) m_started = 1;
    else begin
      acc = req && imem_ready;
      resp = m_out && imem_rvalid;
      if (resp) begin
        if (!m_stale && !redir) begin
          m_have = 1;
          m_inst = imem_rdata;
          m_ipc = m_req_addr;
          m_ipc4 = m_req_addr + 32'd4;
        end
        m_out = 0;
        m_stale = 0;
      end else if (m_out && redir) m_stale = 1;
      if (acc) begin
        m_out = 1;
        m_stale = redir;
        m_req_addr = m_pc;
      end
      if (had && redir) m_have = 0;
      else if (had && if_ready) begin
        m_have = 0;
        m_pc = m_pc + 32'd4;
      end
    end
    if (redir) m_pc = tgt;
  endtask
  task automatic tick();
    cyc++;
    imem_rvalid = pend && due == cyc;
    imem_rdata = imem_rvalid ? inst_of(paddr) : $urandom;
    if (imem_rvalid) pend = 0;
    imem_ready = !pend && ($urandom_range(99) < ready_pct);
    if (imem_req && imem_ready && !rst) begin
      pend = 1;
      due = cyc + int'($urandom_range(lat_max, lat_min));
      paddr = imem_addr;
    end
    model_step();
    @(negedge clk);
    chk("imem_req", imem_req, m_started && !m_out && !m_have);
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", if_valid, m_have);
    chk("if_inst", if_inst, m_inst);
    chk("if_pc", if_pc, m_ipc);
    chk("if_pc_plus4", if_pc_plus4, m_ipc4);
  endtask
  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, RPC);
    chk({tag, "_valid"}, if_valid, 0);
    chk({tag, "_inst"}, if_inst, 0);
    chk({tag, "_pc"}, if_pc, 0);
    chk({tag, "_pc4"}, if_pc_plus4, 0);
  endtask
  initial begin
    imem_ready = 0;
    imem_rvalid = 0;
    imem_rdata = '0;
    if_ready = 1;
    br_taken = 0;
    jmp_taken = 0;
    br_imm = '0;
    br_pc = '0;
    jmp_index = '0;
    jmp_pc = '0;
    tbl[0] = '{1'b1, 1'b0, 16'hFFFC, 32'h0040_0010, 26'h0, 32'h0, 32'h0040_0004};
    tbl[1] = '{1'b1, 1'b0, 16'h0003, 32'h0040_0010, 26'h0, 32'h0, 32'h0040_0020};
    tbl[2] = '{1'b1, 1'b1, 16'h0003, 32'h0040_0010, 26'h0000010, 32'h3FFF_FFFC, 32'h4000_0040};
    tbl[3] = '{1'b1, 1'b0, 16'h0000, 32'hFFFF_FFFC, 26'h0, 32'h0, 32'h0000_0000};
    tbl[4] = '{1'b1, 1'b0, 16'h8000, 32'h0000_0000, 26'h0, 32'h0, 32'hFFFE_0004};
    tbl[5] = '{1'b0, 1'b1, 16'h0000, 32'h0, 26'h3FF_FFFF, 32'hEFFF_FFFC, 32'hFFFF_FFFC};
    @(negedge clk);
    tick();
    tick();
    chk_reset_outputs("rst");
    rst = 0;
    chk("first_req_early", imem_req, 0);
    tick();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, RPC);
    got = 0;
    for (int i = 0; i < 40 && got < 3; i++) begin
      if (if_valid && if_ready) begin
        seen[got] = if_pc;
        chk("stream_inst", if_inst, inst_of(if_pc));
        got++;
      end
      tick();
    end
    chk("stream_count", 32'(got), 3);
    for (int i = 0; i < 3; i++) chk("stream_pc", seen[i], RPC + 32'(4 * i));
    if_ready = 0;
    for (int i = 0; i < 20 && !if_valid; i++) tick();
    chk("stall_valid", if_valid, 1);
    held_inst = if_inst;
    held_pc = if_pc;
    chk("stall_inst_ok", held_inst, inst_of(held_pc));
    repeat (5) begin
      tick();
      chk("stall_inst", if_inst, held_inst);
      chk("stall_pc", if_pc, held_pc);
      chk("stall_no_req", imem_req, 0);
    end
    if_ready = 1;
    tick();
    chk("stall_next_req", imem_req, 1);
    chk("stall_next_addr", imem_addr, held_pc + 32'd4);
    ready_pct = 0;
    foreach (tbl[i]) begin
      for (int k = 0; k < 20 && !imem_req; k++) tick();
      br_taken = tbl[i].br;
      jmp_taken = tbl[i].jmp;
      br_imm = tbl[i].imm;
      br_pc = tbl[i].bpc;
      jmp_index = tbl[i].idx;
      jmp_pc = tbl[i].jpc;
      tick();
      br_taken = 0;
      jmp_taken = 0;
      chk("redir_req", imem_req, 1);
      chk("redir_addr", imem_addr, tbl[i].exp_addr);
    end
    ready_pct = 100;
    lat_min = 3;
    lat_max = 3;
    for (int k = 0; k < 20 && !pend; k++) tick();
    chk("wait_accept", 32'(pend), 1);
    br_taken = 1;
    br_pc = 32'h0040_0010;
    br_imm = 16'h0003;
    tick();
    br_taken = 0;
    for (int k = 0; k < 20 && !imem_req; k++) begin
      chk("wait_no_stale", if_valid, 0);
      tick();
    end
    chk("wait_req", imem_req, 1);
    chk("wait_addr", imem_addr, 32'h0040_0020);
    for (int k = 0; k < 20 && !if_valid; k++) tick();
    chk("wait_pc", if_pc, 32'h0040_0020);
    chk("wait_inst", if_inst, inst_of(32'h0040_0020));
    for (int k = 0; k < 20 && !pend; k++) tick();
    chk("rstw_accept", 32'(pend), 1);
    rst = 1;
    tick();
    rst = 0;
    chk_reset_outputs("rstw");
    for (int k = 0; k < 30 && !if_valid; k++) tick();
    chk("rstw_valid", if_valid, 1);
    chk("rstw_pc", if_pc, RPC);
    chk("rstw_inst", if_inst, inst_of(RPC));
    lat_min = 1;
    lat_max = 4;
    ready_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if_ready = $urandom_range(99) < 70;
      br_taken = $urandom_range(99) < 6;
      jmp_taken = $urandom_range(99) < 4;
      br_imm = 16'($urandom);
      br_pc = $urandom & 32'hFFFF_FFFC;
      jmp_index = 26'($urandom);
      jmp_pc = $urandom & 32'hFFFF_FFFC;
      rst = $urandom_range(199) == 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
